// File: rtl/adc_cfg_sequencer.sv
// Sequencer that plays a small table of SPI words into the SPI4ADC engine.
// Latency: go -> LOAD same edge, spi_start one cycle later; GAP_CYCLES idle between transfers.
// Backpressure: none; waits for spi_done per transfer, bounded by TIMEOUT_CYCLES, abort cancels.
module adc_cfg_sequencer #(
  parameter int DEPTH          = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [35:0]              cfg_wdata,
  input  logic [$clog2(DEPTH):0]   cfg_num,
  input  logic                     go,
  input  logic                     abort,
  input  logic                     spi_done,
  output logic [31:0]              spi_data,
  output logic                     spi_cpol,
  output logic                     spi_cpha,
  output logic                     ps_A0,
  output logic                     ps_A1,
  output logic                     spi_start,
  output logic                     busy,
  output logic                     seq_done,
  output logic                     timeout_err,
  output logic [$clog2(DEPTH)-1:0] cur_idx
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int WCW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GCW  = $clog2(GAP_CYCLES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [IDXW:0]  DEPTH_N  = (IDXW+1)'(DEPTH);
  localparam logic [IDXW:0]  ONE_N    = (IDXW+1)'(1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(TIMEOUT_CYCLES - 1);
  localparam logic [GCW-1:0] GAP_MAX  = GCW'(GAP_CYCLES - 1);

  logic [2:0]      state_q, state_d;
  logic [IDXW:0]   n_q, n_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [GCW-1:0]  gcnt_q, gcnt_d;
  logic            terr_q, terr_d;
  logic [31:0]     data_q, data_d;
  logic            cpol_q, cpol_d;
  logic            cpha_q, cpha_d;
  logic            a1_q, a1_d;
  logic            a0_q, a0_d;
  logic [35:0]     tbl_q [DEPTH];

  logic [35:0]     ent;
  logic [IDXW:0]   num_clamped;
  logic            last_entry;

  assign ent         = tbl_q[idx_q];
  assign num_clamped = (cfg_num > DEPTH_N) ? DEPTH_N : cfg_num;
  assign last_entry  = ({1'b0, idx_q} == (n_q - ONE_N));

  // Configuration table: host may only rewrite it while no sequence is running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (cfg_we && (state_q == S_IDLE)) begin
      tbl_q[cfg_addr] <= cfg_wdata;
    end
  end

  // Next-state logic; abort overrides everything and freezes all other registers.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    gcnt_d  = gcnt_q;
    terr_d  = terr_q;
    data_d  = data_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    a1_d    = a1_q;
    a0_d    = a0_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            n_d     = num_clamped;
            idx_d   = '0;
            terr_d  = 1'b0;
            state_d = (num_clamped == '0) ? S_FINISH : S_LOAD;
          end
        end
        S_LOAD: begin
          cpol_d  = ent[35];
          cpha_d  = ent[34];
          a1_d    = ent[33];
          a0_d    = ent[32];
          data_d  = ent[31:0];
          state_d = S_START;
        end
        S_START: begin
          wcnt_d  = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          // A completion on the timeout edge still counts as a good transfer.
          if (spi_done) begin
            if (last_entry) begin
              state_d = S_FINISH;
            end else begin
              idx_d   = idx_q + 1'b1;
              gcnt_d  = '0;
              state_d = S_GAP;
            end
          end else if (wcnt_q == WAIT_MAX) begin
            terr_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (gcnt_q == GAP_MAX) begin
            state_d = S_LOAD;
          end else begin
            gcnt_d = gcnt_q + 1'b1;
          end
        end
        S_FINISH: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, counters and engine-facing output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      wcnt_q  <= '0;
      gcnt_q  <= '0;
      terr_q  <= 1'b0;
      data_q  <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      a1_q    <= 1'b0;
      a0_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      gcnt_q  <= gcnt_d;
      terr_q  <= terr_d;
      data_q  <= data_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      a1_q    <= a1_d;
      a0_q    <= a0_d;
    end
  end

  assign spi_data    = data_q;
  assign spi_cpol    = cpol_q;
  assign spi_cpha    = cpha_q;
  assign ps_A1       = a1_q;
  assign ps_A0       = a0_q;
  assign spi_start   = (state_q == S_START);
  assign busy        = (state_q != S_IDLE);
  assign seq_done    = (state_q == S_FINISH);
  assign timeout_err = terr_q;
  assign cur_idx     = idx_q;

endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Directed bench for adc_cfg_sequencer with a latency-programmable SPI engine model.
// Inputs driven 1 time unit after posedge, outputs sampled there too (between edges).
// Engine model answers each spi_start after eng_lat edges unless that start is muted.
module tb_adc_cfg_sequencer;
  localparam int DEPTH = 4;
  localparam int GAP   = 16;
  localparam int TO    = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [35:0] cfg_wdata = '0;
  logic [2:0]  cfg_num = '0;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic        spi_done;
  logic [31:0] spi_data;
  logic        spi_cpol, spi_cpha, ps_A0, ps_A1;
  logic        spi_start, busy, seq_done, timeout_err;
  logic [1:0]  cur_idx;

  logic eng_done = 1'b0;
  logic man_done = 1'b0;
  int   eng_lat = 100;
  int   eng_mute_at = -1;
  assign spi_done = eng_done | man_done;

  adc_cfg_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_num(cfg_num), .go(go), .abort(abort), .spi_done(spi_done),
    .spi_data(spi_data), .spi_cpol(spi_cpol), .spi_cpha(spi_cpha),
    .ps_A0(ps_A0), .ps_A1(ps_A1), .spi_start(spi_start), .busy(busy),
    .seq_done(seq_done), .timeout_err(timeout_err), .cur_idx(cur_idx)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every transfer request and every end-of-sequence pulse.
  int          start_cnt = 0;
  int          done_cnt = 0;
  int          start_cyc [64];
  logic [31:0] start_dat [64];
  logic [3:0]  start_mode [64];
  always @(negedge clk) begin
    if (spi_start && start_cnt < 64) begin
      start_cyc[start_cnt]  = cyc;
      start_dat[start_cnt]  = spi_data;
      start_mode[start_cnt] = {spi_cpol, spi_cpha, ps_A1, ps_A0};
      start_cnt++;
    end
    if (seq_done) done_cnt++;
  end

  // Engine model.
  initial begin
    int eng_cnt;
    int my_idx;
    eng_cnt = 0;
    forever begin
      @(negedge clk);
      if (spi_start) begin
        my_idx = eng_cnt;
        eng_cnt++;
        if (my_idx != eng_mute_at) begin
          repeat (eng_lat) @(posedge clk);
          #1 eng_done = 1'b1;
          @(posedge clk);
          #1 eng_done = 1'b0;
        end
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [35:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic run_go(input logic [2:0] num);
    cfg_num = num;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int k;
    k = 0;
    while (!seq_done && k < maxc) begin
      tick();
      k++;
    end
    chk(tag, seq_done, 1);
  endtask

  initial begin
    int base;
    int dbase;
    int k;
    int t_rise;

    // Reset state
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_start", spi_start, 0);
    chk("rst_done", seq_done, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_data", spi_data, 0);
    chk("rst_idx", cur_idx, 0);
    #20 rst = 1'b1;
    tick();

    wr(2'd0, {4'b0110, 32'hAAAA_AAAA});
    wr(2'd1, {4'b1001, 32'h1234_5678});
    wr(2'd2, {4'b1111, 32'hDEAD_BEEF});
    wr(2'd3, {4'b0001, 32'h0000_5555});

    // Basic sequence of three entries
    base = start_cnt; dbase = done_cnt; eng_lat = 100;
    run_go(3'd3);
    chk("b_busy_E", busy, 1);
    chk("b_start_E", spi_start, 0);
    tick();
    chk("b_start_E1", spi_start, 1);
    chk("b_data_E1", spi_data, 32'hAAAA_AAAA);
    chk("b_mode_E1", {spi_cpol, spi_cpha, ps_A1, ps_A0}, 4'b0110);
    wait_done("b_seqdone", 1000);
    chk("b_nstart", start_cnt - base, 3);
    chk("b_dat1", start_dat[base+1], 32'h1234_5678);
    chk("b_mode1", start_mode[base+1], 4'b1001);
    chk("b_dat2", start_dat[base+2], 32'hDEAD_BEEF);
    chk("b_mode2", start_mode[base+2], 4'b1111);
    chk("b_space01", start_cyc[base+1] - start_cyc[base], 100 + GAP + 2);
    chk("b_space12", start_cyc[base+2] - start_cyc[base+1], 100 + GAP + 2);
    chk("b_terr", timeout_err, 0);
    tick();
    chk("b_busy_end", busy, 0);
    chk("b_done_once", done_cnt - dbase, 1);

    // Timeout on entry 1
    base = start_cnt; eng_mute_at = start_cnt + 1;
    run_go(3'd3);
    k = 0;
    while (!timeout_err && k < 5000) begin
      tick();
      k++;
    end
    chk("t_terr_set", timeout_err, 1);
    t_rise = cyc;
    chk("t_terr_time", t_rise - start_cyc[base+1], TO + 1);
    chk("t_seqdone", seq_done, 1);
    tick();
    chk("t_busy_end", busy, 0);
    chk("t_nstart", start_cnt - base, 2);
    chk("t_terr_sticky", timeout_err, 1);
    eng_mute_at = -1;

    // cfg_num = 0: immediate finish, clears the error
    base = start_cnt;
    run_go(3'd0);
    chk("z_seqdone", seq_done, 1);
    chk("z_terr_clr", timeout_err, 0);
    tick();
    chk("z_seqdone_1cyc", seq_done, 0);
    chk("z_busy", busy, 0);
    repeat (3) tick();
    chk("z_nstart", start_cnt - base, 0);

    // Abort during the gap after entry 0
    base = start_cnt; dbase = done_cnt;
    run_go(3'd3);
    k = 0;
    while (cur_idx != 2'd1 && k < 500) begin
      tick();
      k++;
    end
    chk("a_in_gap", cur_idx, 1);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("a_busy", busy, 0);
    chk("a_seqdone", seq_done, 0);
    repeat (300) tick();
    chk("a_nstart", start_cnt - base, 1);
    chk("a_ndone", done_cnt - dbase, 0);
    chk("a_data_hold", spi_data, 32'hAAAA_AAAA);
    chk("a_mode_hold", {spi_cpol, spi_cpha, ps_A1, ps_A0}, 4'b0110);

    // cfg_num above DEPTH clamps to DEPTH transfers
    base = start_cnt; eng_lat = 5;
    run_go(3'd7);
    wait_done("c_seqdone", 1000);
    chk("c_nstart", start_cnt - base, 4);
    chk("c_dat3", start_dat[base+3], 32'h0000_5555);
    chk("c_mode3", start_mode[base+3], 4'b0001);
    chk("c_idx", cur_idx, 3);
    tick();

    // spi_done on the timeout edge wins; go/cfg_we while busy are ignored
    base = start_cnt; eng_mute_at = start_cnt;
    run_go(3'd1);
    for (int i = 0; i < TO + 1; i++) begin
      if (i == 10) begin
        go = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 36'hF_FFFF_FFFF;
      end else begin
        go = 1'b0; cfg_we = 1'b0;
      end
      tick();
    end
    chk("s_still_wait", seq_done, 0);
    chk("s_busy", busy, 1);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("s_seqdone", seq_done, 1);
    chk("s_terr", timeout_err, 0);
    tick();
    chk("s_nstart", start_cnt - base, 1);
    eng_mute_at = -1;
    run_go(3'd1);
    tick();
    chk("s_tbl_data", spi_data, 32'hAAAA_AAAA);
    chk("s_tbl_mode", {spi_cpol, spi_cpha, ps_A1, ps_A0}, 4'b0110);
    wait_done("s_seqdone2", 100);
    tick();

    // Asynchronous reset in the middle of WAIT
    eng_mute_at = start_cnt;
    run_go(3'd2);
    tick();
    repeat (20) tick();
    #5 rst = 1'b0;
    #1;
    chk("r_busy", busy, 0);
    chk("r_data", spi_data, 0);
    chk("r_mode", {spi_cpol, spi_cpha, ps_A1, ps_A0}, 4'b0000);
    chk("r_start", spi_start, 0);
    #1 rst = 1'b1;
    tick();
    chk("r_idle", busy, 0);
    eng_mute_at = -1;
    base = start_cnt;
    run_go(3'd1);
    chk("r_go_busy", busy, 1);
    chk("r_go_idx", cur_idx, 0);
    tick();
    chk("r_go_start", spi_start, 1);
    chk("r_go_data", spi_data, 0);
    wait_done("r_seqdone", 100);
    chk("r_nstart", start_cnt - base, 1);
    chk("r_terr", timeout_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
